// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first, through a single
// full-adder slice, presenting {cout,sum} with a one-cycle done pulse.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  // S keeps only the WIDTH-1 partial bits; the slice supplies the last one directly
  logic [WIDTH-2:0] s_sh_r;
  logic [WIDTH-1:0] s_next_s;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             arm_r;
  logic             load_s;
  logic             last_s;
  logic             slice_sum_s;
  logic             slice_carry_s;

  assign {slice_carry_s, slice_sum_s} = full_add(a_sh_r[0], b_sh_r[0], carry_r);
  assign s_next_s = {slice_sum_s, s_sh_r};

  // Next-state decode; start only honoured in IDLE/DONE and once armed after reset
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && arm_r) begin
          load_s       = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s       = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (start && arm_r) begin
          load_s       = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register with registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Blocks start sampling on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_r <= 1'b0;
    end else begin
      arm_r <= 1'b1;
    end
  end

  // Operand shifters, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      s_sh_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else if (load_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      s_sh_r  <= '0;
      carry_r <= cin;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
      s_sh_r  <= s_next_s[WIDTH-1:1];
      carry_r <= slice_carry_s;
      cnt_r   <= cnt_r + 1'b1;
    end
  end

  // Result registers update only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (last_s) begin
      sum_r  <= s_next_s;
      cout_r <= slice_carry_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

  bit_serial_adder_checker #(.WIDTH(WIDTH)) u_checker (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy_r),
    .done  (done_r),
    .sum   (sum_r),
    .cout  (cout_r)
  );

endmodule

// Protocol properties on the adder outputs.
module bit_serial_adder_checker #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  input logic             busy,
  input logic             done,
  input logic [WIDTH-1:0] sum,
  input logic             cout
);

  busy_done_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

  done_single_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

  result_held: assert property (@(posedge clk) disable iff (!rst_n) !done |-> $stable({cout, sum}));

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench: drivers push a+b+cin into per-instance queues, negedge monitors
// pop on done and compare; directed cases cover latency, ignore, reset abort, back-to-back.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int checks = 0;
  int failures = 0;

  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic [8:0]  last8, e8;
  logic [16:0] last16, e16;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: pop on done, otherwise result must hold
  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = '0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("result8", {cout8, sum8}, e8);
      end
      last8 = {cout8, sum8};
    end else begin
      chk("hold8", {cout8, sum8}, last8);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last16 = '0;
    end else if (done16) begin
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'd1, 32'd0);
      end else begin
        e16 = q16.pop_front();
        chk("result16", {cout16, sum16}, e16);
      end
      last16 = {cout16, sum16};
    end else begin
      chk("hold16", {cout16, sum16}, last16);
    end
  end

  // One 8-bit operation with latency/busy checks; optional ignored start during RUN
  task automatic op8(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                     input int inject, input string nm);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    @(posedge clk); #2;
    start8 = 1'b1; a8 = oa; b8 = ob; cin8 = oc;
    q8.push_back({1'b0, oa} + {1'b0, ob} + {8'd0, oc});
    @(posedge clk); #2;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int n = 1; n <= 20 && done_at == 0; n++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) done_at = n;
      #1;
      if (n == inject) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else if (n == inject + 1) begin
        start8 = 1'b0;
      end
    end
    chk({nm, "_done_latency"}, done_at, 32'd9);
    chk({nm, "_busy_cycles"}, busy_n, 32'd8);
    @(negedge clk);
    chk({nm, "_done_pulse_end"}, {31'd0, done8}, 32'd0);
    chk({nm, "_idle_busy"}, {31'd0, busy8}, 32'd0);
  endtask

  task automatic rand8(input int nops);
    logic [7:0] ra, rb;
    logic       rc;
    @(posedge clk); #2;
    for (int i = 0; i < nops; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      start8 = 1'b1; a8 = ra; b8 = rb; cin8 = rc;
      q8.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      @(posedge clk); #2;
      start8 = 1'b0;
      repeat (8 + $urandom_range(0, 2)) begin
        @(posedge clk); #2;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
  endtask

  task automatic rand16(input int nops);
    logic [15:0] ra, rb;
    logic        rc;
    @(posedge clk); #2;
    for (int i = 0; i < nops; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      start16 = 1'b1; a16 = ra; b16 = rb; cin16 = rc;
      q16.push_back({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
      @(posedge clk); #2;
      start16 = 1'b0;
      repeat (16 + $urandom_range(0, 2)) begin
        @(posedge clk); #2;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_busy8", {31'd0, busy8}, 32'd0);
    chk("reset_done8", {31'd0, done8}, 32'd0);
    chk("reset_result8", {cout8, sum8}, 32'd0);
    chk("reset_busy16", {31'd0, busy16}, 32'd0);
    chk("reset_result16", {cout16, sum16}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    op8(8'h5A, 8'h3C, 1'b0, 0, "add_5a_3c");
    op8(8'hFF, 8'h01, 1'b0, 0, "ovf_ff_01");
    op8(8'hFF, 8'h00, 1'b1, 0, "ovf_ff_00_cin");
    op8(8'h12, 8'h34, 1'b0, 3, "ignore_start");

    // Reset in the middle of RUN aborts with no done pulse
    @(posedge clk); #2;
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    @(posedge clk); #2;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy8}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_result", {cout8, sum8}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    op8(8'h80, 8'h80, 1'b0, 0, "after_abort");

    // Back-to-back: start held through the first DONE launches the second op
    @(posedge clk); #2;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    q8.push_back(9'h002);
    @(posedge clk); #2;
    a8 = 8'h10; b8 = 8'h20;
    q8.push_back(9'h030);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      chk($sformatf("b2b_busy_%0d", n), {31'd0, busy8}, (n == 9 || n == 18) ? 32'd0 : 32'd1);
      chk($sformatf("b2b_done_%0d", n), {31'd0, done8}, (n == 9 || n == 18) ? 32'd1 : 32'd0);
      #1;
      if (n == 10) start8 = 1'b0;
    end
    repeat (2) @(posedge clk);

    fork
      rand8(1000);
      rand16(1000);
    join

    for (int t = 0; t < 100 && (q8.size() != 0 || q16.size() != 0); t++) @(negedge clk);
    chk("drain8", q8.size(), 32'd0);
    chk("drain16", q16.size(), 32'd0);
    repeat (2) @(negedge clk);
    chk("final_busy8", {31'd0, busy8}, 32'd0);
    chk("final_busy16", {31'd0, busy16}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to add a, b, cin; sampled only in IDLE or DONE.
REQ-005 Port: a  input  WIDTH  operand A; sampled in the start cycle only.
REQ-006 Port: b  input  WIDTH  operand B; sampled in the start cycle only.
REQ-007 Port: cin  input  1  carry-in; sampled in the start cycle only.
REQ-008 Port: busy  output  1  high while the addition is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse marking a new valid result.
REQ-010 Port: sum  output  WIDTH  registered result, held between completions.
REQ-011 Port: cout  output  1  registered final carry-out, held between completions.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, through exactly one 1-bit full-adder slice (inputs: bit A, bit B, carry register; outputs: sum bit, carry).
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 -> latch a, b into shift registers A, B, cin into carry register, clear bit counter, go to RUN; start=0 -> stay.
REQ-015 RUN: each cycle, slice consumes A[0], B[0], carry; sum bit shifts into MSB of result shift register S; A, B shift right; carry <= slice carry-out; counter increments.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge ending the WIDTH-th RUN cycle, sum <= S (final), cout <= slice carry-out, state -> DONE.
REQ-017 DONE: done=1 for exactly this one cycle; next state IDLE, or RUN if start=1 (new operands latched as in REQ-014).
REQ-018 Latency: done SHALL be high in the cycle following the WIDTH-th clock edge after the edge that sampled start (start at edge 0 -> done visible after edge WIDTH).
REQ-019 busy SHALL be 1 exactly in RUN, 0 in IDLE and DONE.
REQ-020 start asserted while in RUN SHALL be ignored; the in-flight operation and its operands SHALL be unaffected.
REQ-021 a, b, cin changes after the start cycle SHALL not affect the result.
REQ-022 sum and cout SHALL change only on the edge entering DONE (or on reset); intermediate shift contents SHALL never appear on sum.
REQ-023 Overflow: carry beyond bit WIDTH-1 SHALL appear only on cout; sum wraps modulo 2^WIDTH.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL immediately (without clock) force state IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, A=B=S=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL run normally.
REQ-027 Release of rst_n SHALL be synchronised by the surrounding design; start SHALL not be sampled on the first edge after release.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles, done pulse once, sum=0x96, cout=0.
REQ-029 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-030 Start 0x12+0x34 then assert start with a=0xFF, b=0xFF at RUN cycle 3 -> ignored; result sum=0x46, cout=0, single done pulse.
REQ-031 rst_n low at RUN cycle 4 of 0x80+0x80 -> outputs all 0 at once, no done; after release, 0x80+0x80 -> sum=0x00, cout=1.
REQ-032 Back-to-back: start held high through DONE of 0x01+0x01 with next operands 0x10+0x20 -> done pulses after edge 8 and edge 17 (DONE cycle starts second op), sums 0x02 then 0x30, busy low only during each DONE cycle.
REQ-033 Random: 1000 random a, b, cin at WIDTH=8 and WIDTH=16 -> {cout,sum} matches a+b+cin every completion; sum stable between done pulses.
